hour_set_ctrl: RTL and testbench

Time-set controller that drives the parallel-load side of the 0–23 hour counter. It debounces three push-buttons (Set, Inc, Dec) and captures the running hour into an edit register. The operator adjusts that value with wrap-around and auto-repeat. On exit the controller issues a clean, setup/hold-safe load strobe (HOUR_OUT + LD) back into the hour counter.

---
 rtl/hour_set_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_hour_set_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hour_set_ctrl.sv
// Hour time-set controller: debounces Set/Inc/Dec, edits a captured hour modulo 24 with
// auto-repeat, then commits it to the hour counter with a setup/hold-safe LD strobe.
module hour_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned LD_WIDTH        = 2
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Set_Btn,
  input  logic       Inc_Btn,
  input  logic       Dec_Btn,
  input  logic [4:0] CUR_HOUR,
  output logic [4:0] HOUR_OUT,
  output logic       LD,
  output logic       Setting
);

  localparam int unsigned NumBtn = 3;
  localparam int unsigned BtnSet = 0;
  localparam int unsigned BtnInc = 1;
  localparam int unsigned BtnDec = 2;

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  localparam int unsigned LdW    = $clog2(LD_WIDTH + 1);

  localparam logic [4:0] MaxHour = 5'd23;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StAdjust,
    StLdSetup,
    StLdPulse,
    StLdHold
  } state_e;

  // Button synchronizers and debouncers
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] lvl_q, lvl_d;
  logic [NumBtn-1:0] prev_q;
  logic [NumBtn-1:0] press;
  logic [DbW-1:0]    db_cnt_q [NumBtn];
  logic [DbW-1:0]    db_cnt_d [NumBtn];

  assign btn_raw = {Dec_Btn, Inc_Btn, Set_Btn};

  // Counter tracks consecutive cycles the synchronized input disagrees with the level.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NumBtn; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign press = lvl_q & ~prev_q;

  logic set_press;
  logic inc_lvl, dec_lvl;
  logic inc_press, dec_press;

  assign set_press = press[BtnSet];
  assign inc_lvl   = lvl_q[BtnInc];
  assign dec_lvl   = lvl_q[BtnDec];
  assign inc_press = press[BtnInc];
  assign dec_press = press[BtnDec];

  // State, edit register and repeat/pulse counters
  state_e          state_q, state_d;
  logic [4:0]      hour_q, hour_d;
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_first_q, rpt_first_d;
  logic [LdW-1:0]  ld_cnt_q, ld_cnt_d;
  logic            ld_q, ld_d;
  logic            setting_q, setting_d;

  logic step;
  logic step_up, step_dn;

  // Auto-repeat only runs while exactly one of Inc/Dec is held in ADJUST; anything else
  // rewinds it so the next step is a fresh press followed by the long initial delay.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    step        = 1'b0;
    if (state_q == StAdjust && (inc_lvl ^ dec_lvl)) begin
      if (inc_press || dec_press) begin
        step = 1'b1;
      end else if (rpt_first_q) begin
        if (rpt_cnt_q == RptW'(REPEAT_DELAY - 1)) begin
          step        = 1'b1;
          rpt_first_d = 1'b0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end else begin
        rpt_first_d = 1'b0;
        if (rpt_cnt_q == RptW'(REPEAT_RATE - 1)) begin
          step = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
    end
  end

  assign step_up = step & inc_lvl;
  assign step_dn = step & dec_lvl;

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    ld_cnt_d = ld_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (set_press) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        hour_d  = (CUR_HOUR > MaxHour) ? 5'd0 : CUR_HOUR;
        state_d = StAdjust;
      end
      StAdjust: begin
        // Set wins over a same-cycle step; the step is dropped.
        if (set_press) begin
          state_d = StLdSetup;
        end else if (step_up) begin
          hour_d = (hour_q >= MaxHour) ? 5'd0 : hour_q + 5'd1;
        end else if (step_dn) begin
          hour_d = (hour_q == 5'd0 || hour_q > MaxHour) ? MaxHour : hour_q - 5'd1;
        end
      end
      StLdSetup: begin
        ld_cnt_d = '0;
        state_d  = StLdPulse;
      end
      StLdPulse: begin
        if (ld_cnt_q == LdW'(LD_WIDTH - 1)) begin
          state_d = StLdHold;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      StLdHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  assign ld_d      = (state_d == StLdPulse);
  assign setting_d = (state_d != StIdle);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q     <= StIdle;
      hour_q      <= '0;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      ld_cnt_q    <= '0;
      ld_q        <= 1'b0;
      setting_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      ld_cnt_q    <= ld_cnt_d;
      ld_q        <= ld_d;
      setting_q   <= setting_d;
    end
  end

  assign HOUR_OUT = hour_q;
  assign LD       = ld_q;
  assign Setting  = setting_q;

endmodule

// File: tb/tb_hour_set_ctrl.sv
// Directed bench for hour_set_ctrl: reset, capture/commit, wrap, auto-repeat, bounce,
// simultaneous buttons and reset during the load pulse.
module tb_hour_set_ctrl;

  logic       clk;
  logic       clr;
  logic       set_btn, inc_btn, dec_btn;
  logic [4:0] cur_hour;
  logic [4:0] hour_out;
  logic       ld;
  logic       setting;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hour_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (4),
    .LD_WIDTH       (2)
  ) dut (
    .Clk     (clk),
    .Clr     (clr),
    .Set_Btn (set_btn),
    .Inc_Btn (inc_btn),
    .Dec_Btn (dec_btn),
    .CUR_HOUR(cur_hour),
    .HOUR_OUT(hour_out),
    .LD      (ld),
    .Setting (setting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: set_btn = v;
      1: inc_btn = v;
      default: dec_btn = v;
    endcase
  endtask

  task automatic press(input int which, input int hold, input int settle);
    drive(which, 1'b1);
    cyc(hold);
    drive(which, 1'b0);
    cyc(settle);
  endtask

  task automatic capture(input logic [4:0] h);
    cur_hour = h;
    press(0, 6, 10);
  endtask

  task automatic commit();
    press(0, 6, 10);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_btn = i[0];
      inc_btn = ~i[0];
      dec_btn = i[1];
      cyc(1);
    end
    total_cnt++;
    if (hour_out !== 5'd0) $display("FAIL reset_hour: got %0d want 0", hour_out);
    else pass_cnt++;
    total_cnt++;
    if (ld !== 1'b0) $display("FAIL reset_ld: got %b want 0", ld);
    else pass_cnt++;
    total_cnt++;
    if (setting !== 1'b0) $display("FAIL reset_setting: got %b want 0", setting);
    else pass_cnt++;
    set_btn = 1'b0;
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    cyc(1);
    clr = 1'b1;
    cyc(12);
    total_cnt++;
    if (setting !== 1'b0 || ld !== 1'b0)
      $display("FAIL reset_idle: got setting=%b ld=%b want 0 0", setting, ld);
    else pass_cnt++;
  endtask

  task automatic test_capture_commit();
    int first_rise;
    int ld_cycles;
    int hour_bad;
    logic set_c10, set_c11;
    capture(5'd17);
    total_cnt++;
    if (hour_out !== 5'd17 || setting !== 1'b1)
      $display("FAIL capture_17: got hour=%0d setting=%b want 17 1", hour_out, setting);
    else pass_cnt++;
    press(1, 6, 10);
    total_cnt++;
    if (hour_out !== 5'd18) $display("FAIL inc_17: got %0d want 18", hour_out);
    else pass_cnt++;
    first_rise = -1;
    ld_cycles  = 0;
    hour_bad   = 0;
    set_c10    = 1'b0;
    set_c11    = 1'b1;
    set_btn    = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      cyc(1);
      if (c == 6) set_btn = 1'b0;
      if (ld === 1'b1) begin
        ld_cycles++;
        if (first_rise < 0) first_rise = c;
      end
      if (hour_out !== 5'd18) hour_bad++;
      if (c == 10) set_c10 = setting;
      if (c == 11) set_c11 = setting;
    end
    total_cnt++;
    if (first_rise != 8) $display("FAIL ld_rise_cycle: got %0d want 8", first_rise);
    else pass_cnt++;
    total_cnt++;
    if (ld_cycles != 2) $display("FAIL ld_width: got %0d want 2", ld_cycles);
    else pass_cnt++;
    total_cnt++;
    if (hour_bad != 0) $display("FAIL hour_stable: got %0d bad cycles want 0", hour_bad);
    else pass_cnt++;
    total_cnt++;
    if (set_c10 !== 1'b1 || set_c11 !== 1'b0)
      $display("FAIL setting_end: got c10=%b c11=%b want 1 0", set_c10, set_c11);
    else pass_cnt++;
    press(1, 6, 10);
    total_cnt++;
    if (hour_out !== 5'd18 || setting !== 1'b0)
      $display("FAIL idle_inc_ignored: got hour=%0d setting=%b want 18 0", hour_out, setting);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    capture(5'd23);
    total_cnt++;
    if (hour_out !== 5'd23) $display("FAIL capture_23: got %0d want 23", hour_out);
    else pass_cnt++;
    press(1, 6, 10);
    total_cnt++;
    if (hour_out !== 5'd0) $display("FAIL wrap_up: got %0d want 0", hour_out);
    else pass_cnt++;
    commit();
    capture(5'd0);
    press(2, 6, 10);
    total_cnt++;
    if (hour_out !== 5'd23) $display("FAIL wrap_down: got %0d want 23", hour_out);
    else pass_cnt++;
    commit();
    capture(5'd27);
    total_cnt++;
    if (hour_out !== 5'd0) $display("FAIL capture_27: got %0d want 0", hour_out);
    else pass_cnt++;
    commit();
  endtask

  task automatic test_auto_repeat();
    capture(5'd5);
    inc_btn = 1'b1;
    cyc(14);
    total_cnt++;
    if (hour_out !== 5'd6) $display("FAIL repeat_before_delay: got %0d want 6", hour_out);
    else pass_cnt++;
    cyc(1);
    total_cnt++;
    if (hour_out !== 5'd7) $display("FAIL repeat_first: got %0d want 7", hour_out);
    else pass_cnt++;
    cyc(12);
    total_cnt++;
    if (hour_out !== 5'd10) $display("FAIL repeat_held: got %0d want 10", hour_out);
    else pass_cnt++;
    inc_btn = 1'b0;
    cyc(12);
    total_cnt++;
    if (hour_out !== 5'd11) $display("FAIL repeat_release: got %0d want 11", hour_out);
    else pass_cnt++;
    commit();
  endtask

  task automatic test_bounce_simul();
    capture(5'd12);
    inc_btn = 1'b1;
    cyc(3);
    inc_btn = 1'b0;
    cyc(12);
    total_cnt++;
    if (hour_out !== 5'd12) $display("FAIL glitch_3: got %0d want 12", hour_out);
    else pass_cnt++;
    inc_btn = 1'b1;
    cyc(4);
    inc_btn = 1'b0;
    cyc(12);
    total_cnt++;
    if (hour_out !== 5'd13) $display("FAIL pulse_4: got %0d want 13", hour_out);
    else pass_cnt++;
    inc_btn = 1'b1;
    dec_btn = 1'b1;
    cyc(20);
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    cyc(12);
    total_cnt++;
    if (hour_out !== 5'd13) $display("FAIL inc_dec_both: got %0d want 13", hour_out);
    else pass_cnt++;
    set_btn = 1'b1;
    inc_btn = 1'b1;
    cyc(6);
    set_btn = 1'b0;
    inc_btn = 1'b0;
    cyc(10);
    total_cnt++;
    if (hour_out !== 5'd13 || setting !== 1'b0)
      $display("FAIL set_inc_same: got hour=%0d setting=%b want 13 0", hour_out, setting);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    int ld_seen;
    capture(5'd9);
    total_cnt++;
    if (hour_out !== 5'd9) $display("FAIL capture_9: got %0d want 9", hour_out);
    else pass_cnt++;
    set_btn = 1'b1;
    cyc(6);
    set_btn = 1'b0;
    cyc(2);
    total_cnt++;
    if (ld !== 1'b1) $display("FAIL ld_before_clr: got %b want 1", ld);
    else pass_cnt++;
    #1 clr = 1'b0;
    #1;
    total_cnt++;
    if (ld !== 1'b0 || hour_out !== 5'd0 || setting !== 1'b0)
      $display("FAIL clr_mid_pulse: got ld=%b hour=%0d setting=%b want 0 0 0",
               ld, hour_out, setting);
    else pass_cnt++;
    cyc(2);
    clr = 1'b1;
    ld_seen = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (ld === 1'b1 || setting === 1'b1) ld_seen++;
    end
    total_cnt++;
    if (ld_seen != 0) $display("FAIL no_ld_after_clr: got %0d active cycles want 0", ld_seen);
    else pass_cnt++;
  endtask

  initial begin
    clr      = 1'b0;
    set_btn  = 1'b0;
    inc_btn  = 1'b0;
    dec_btn  = 1'b0;
    cur_hour = 5'd0;
    cyc(1);
    test_reset();
    test_capture_commit();
    test_wrap();
    test_auto_repeat();
    test_bounce_simul();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
